// File: rtl/bz_audio_pkg.sv
// Shared types for the noise-burst sound-effect stage: envelope state and PCM sample.
package bz_audio_pkg;

    typedef enum logic [1:0] {
        ENV_IDLE  = 2'd0,
        ENV_HOLD  = 2'd1,
        ENV_DECAY = 2'd2
    } env_state_t;

    typedef logic signed [15:0] audio_sample_t;

endpackage

// File: rtl/bz_sfx_envelope.sv
// One hold/decay envelope channel: holds at the start level, then steps down once
// every DIV ticks until it reaches zero. Produces the signed, noise-gated channel value.
module bz_sfx_envelope
    import bz_audio_pkg::*;
#(
    parameter int ENV_W      = 8,
    parameter int HOLD_TICKS = 96,
    parameter int DIV        = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick,
    input  logic                    clr,
    input  logic                    trig,
    input  logic [ENV_W-1:0]        start_lvl,
    input  logic                    noise,
    output logic signed [ENV_W:0]   value,
    output logic                    active
);

    localparam int HCW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;

    env_state_t       state_q, state_d;
    logic [ENV_W-1:0] env_q, env_d;
    logic [HCW-1:0]   hold_q, hold_d;
    logic [DCW-1:0]   div_q, div_d;
    logic             active_q, active_d;

    // Next-state: clear beats trigger, trigger beats tick.
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        hold_d  = hold_q;
        div_d   = div_q;
        if (clr) begin
            state_d = ENV_IDLE;
            env_d   = {ENV_W{1'b0}};
            hold_d  = {HCW{1'b0}};
            div_d   = {DCW{1'b0}};
        end else if (trig) begin
            state_d = ENV_HOLD;
            env_d   = start_lvl;
            hold_d  = {HCW{1'b0}};
            div_d   = {DCW{1'b0}};
        end else if (tick) begin
            case (state_q)
                ENV_IDLE: begin
                    state_d = ENV_IDLE;
                end
                ENV_HOLD: begin
                    if (hold_q == HCW'(HOLD_TICKS - 1)) begin
                        state_d = ENV_DECAY;
                        div_d   = {DCW{1'b0}};
                    end else begin
                        hold_d = hold_q + {{(HCW-1){1'b0}}, 1'b1};
                    end
                end
                ENV_DECAY: begin
                    if (div_q == DCW'(DIV - 1)) begin
                        div_d = {DCW{1'b0}};
                        // The decrement that lands on zero ends the burst.
                        if (env_q <= {{(ENV_W-1){1'b0}}, 1'b1}) begin
                            env_d   = {ENV_W{1'b0}};
                            state_d = ENV_IDLE;
                        end else begin
                            env_d = env_q - {{(ENV_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        div_d = div_q + {{(DCW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_d = ENV_IDLE;
                    env_d   = {ENV_W{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
        active_d = (state_d != ENV_IDLE);
    end

    // Envelope state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ENV_IDLE;
            env_q    <= {ENV_W{1'b0}};
            hold_q   <= {HCW{1'b0}};
            div_q    <= {DCW{1'b0}};
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            env_q    <= env_d;
            hold_q   <= hold_d;
            div_q    <= div_d;
            active_q <= active_d;
        end
    end

    // Noise-gated channel value; silent when idle.
    always_comb begin
        if (state_q == ENV_IDLE) begin
            value = {(ENV_W+1){1'b0}};
        end else if (noise) begin
            value = $signed({1'b0, env_q});
        end else begin
            value = -$signed({1'b0, env_q});
        end
    end

    assign active = active_q;

endmodule

// File: rtl/bz_noise_sfx.sv
// Noise-burst sound effects: two envelope-gated noise channels summed and scaled
// into a signed 16-bit PCM sample, refreshed on each 6 kHz tick.
module bz_noise_sfx
    import bz_audio_pkg::*;
#(
    parameter int ENV_W      = 8,
    parameter int HOLD_TICKS = 96,
    parameter int EXPL_DIV   = 24,
    parameter int SHELL_DIV  = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_6KHz_en,
    input  logic        ampSD,
    input  logic        noise_expl,
    input  logic        noise_shell,
    input  logic        trig_expl,
    input  logic        trig_shell,
    input  logic        loud_expl,
    output logic [15:0] sample_out,
    output logic [1:0]  busy
);

    localparam int               SHIFT    = 14 - ENV_W;
    localparam logic [ENV_W-1:0] LVL_FULL = {ENV_W{1'b1}};
    localparam logic [ENV_W-1:0] LVL_HALF = {1'b1, {(ENV_W-1){1'b0}}};

    logic                  clr_s;
    logic [ENV_W-1:0]      expl_lvl_s;
    logic signed [ENV_W:0] v_expl_s, v_shell_s;
    logic                  expl_active_s, shell_active_s;
    logic signed [ENV_W+1:0] sum_s;
    audio_sample_t         scaled_s, sample_d, sample_q;

    assign clr_s = ~ampSD;

    // Explosion start level follows the loudness bit sampled with its trigger.
    always_comb begin
        if (loud_expl) begin
            expl_lvl_s = LVL_FULL;
        end else begin
            expl_lvl_s = LVL_HALF;
        end
    end

    bz_sfx_envelope #(
        .ENV_W      (ENV_W),
        .HOLD_TICKS (HOLD_TICKS),
        .DIV        (EXPL_DIV)
    ) u_expl (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (clk_6KHz_en),
        .clr       (clr_s),
        .trig      (trig_expl),
        .start_lvl (expl_lvl_s),
        .noise     (noise_expl),
        .value     (v_expl_s),
        .active    (expl_active_s)
    );

    bz_sfx_envelope #(
        .ENV_W      (ENV_W),
        .HOLD_TICKS (HOLD_TICKS),
        .DIV        (SHELL_DIV)
    ) u_shell (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (clk_6KHz_en),
        .clr       (clr_s),
        .trig      (trig_shell),
        .start_lvl (LVL_FULL),
        .noise     (noise_shell),
        .value     (v_shell_s),
        .active    (shell_active_s)
    );

    // Sum and scale to full 16-bit range; the sum cannot overflow, so no saturation.
    always_comb begin
        sum_s    = (ENV_W+2)'(v_expl_s) + (ENV_W+2)'(v_shell_s);
        scaled_s = audio_sample_t'(16'(sum_s) <<< SHIFT);
        if (!ampSD) begin
            sample_d = 16'sd0;
        end else if (clk_6KHz_en) begin
            sample_d = scaled_s;
        end else begin
            sample_d = sample_q;
        end
    end

    // Output sample register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= 16'sd0;
        end else begin
            sample_q <= sample_d;
        end
    end

    assign sample_out = sample_q;
    assign busy       = {shell_active_s, expl_active_s};

endmodule

// File: tb/tb_bz_noise_sfx.sv
// Randomized and directed bench for bz_noise_sfx against a tick-count envelope model.
module tb_bz_noise_sfx;

    localparam int ENV_W     = 8;
    localparam int HOLD      = 96;
    localparam int DIV_X     = 24;
    localparam int DIV_S     = 6;
    localparam int FULL      = (1 << ENV_W) - 1;
    localparam int HALF      = 1 << (ENV_W - 1);
    localparam int SCALE     = 1 << (14 - ENV_W);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0, amp = 1'b1;
    logic        ne = 1'b0, ns = 1'b0, tx = 1'b0, tsh = 1'b0, loud = 1'b0;
    logic [15:0] sample_out;
    logic [1:0]  busy;

    int checks = 0;
    int failures = 0;

    bz_noise_sfx #(
        .ENV_W(ENV_W), .HOLD_TICKS(HOLD), .EXPL_DIV(DIV_X), .SHELL_DIV(DIV_S)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_6KHz_en(tick), .ampSD(amp),
        .noise_expl(ne), .noise_shell(ns), .trig_expl(tx), .trig_shell(tsh),
        .loud_expl(loud), .sample_out(sample_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: each channel is described by ticks counted since its trigger and its start level.
    int  t_x = 0, t_s = 0, l_x = 0, l_s = 0;
    bit  act_x = 1'b0, act_s = 1'b0;
    logic [15:0] exp_sample = 16'd0;

    function automatic int env_of(input int t, input int l, input int dv);
        if (t < HOLD) return l;
        return l - (t - HOLD) / dv;
    endfunction

    function automatic int chan(input bit a, input int t, input int l, input int dv, input logic n);
        if (!a) return 0;
        return n ? env_of(t, l, dv) : -env_of(t, l, dv);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_x = 1'b0; act_s = 1'b0; t_x = 0; t_s = 0; exp_sample = 16'd0;
        end else if (!amp) begin
            act_x = 1'b0; act_s = 1'b0; exp_sample = 16'd0;
        end else begin
            if (tick)
                exp_sample = 16'((chan(act_x, t_x, l_x, DIV_X, ne) +
                                  chan(act_s, t_s, l_s, DIV_S, ns)) * SCALE);
            if (tx) begin
                act_x = 1'b1; t_x = 0; l_x = loud ? FULL : HALF;
            end else if (tick && act_x) begin
                t_x++;
                if (t_x >= HOLD + l_x * DIV_X) act_x = 1'b0;
            end
            if (tsh) begin
                act_s = 1'b1; t_s = 0; l_s = FULL;
            end else if (tick && act_s) begin
                t_s++;
                if (t_s >= HOLD + l_s * DIV_S) act_s = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        checks++;
        if (sample_out !== exp_sample) begin
            failures++;
            $display("FAIL model_sample t=%0t got=%0d want=%0d", $time,
                     $signed(sample_out), $signed(exp_sample));
        end
        checks++;
        if (busy !== {act_s, act_x}) begin
            failures++;
            $display("FAIL model_busy t=%0t got=%b want=%b", $time, busy, {act_s, act_x});
        end
    end

    task automatic lit(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic cyc(input logic k, input logic x, input logic s, input logic ld,
                       input logic nx, input logic nsh, input logic a);
        @(negedge clk);
        tick = k; tx = x; tsh = s; loud = ld; ne = nx; ns = nsh; amp = a;
        @(posedge clk);
        #1;
    endtask

    int n;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        lit("reset_sample", int'($signed(sample_out)), 0);
        lit("reset_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Loud explosion, steady noise: hold then first decrement.
        cyc(0, 1, 0, 1, 1, 0, 1);
        for (int i = 1; i <= 121; i++) begin
            cyc(1, 0, 0, 0, 1, 0, 1);
            if (i == 1)   lit("expl_first", int'($signed(sample_out)), 16320);
            if (i == 120) lit("expl_last_full", int'($signed(sample_out)), 16320);
            if (i == 121) lit("expl_first_dec", int'($signed(sample_out)), 16256);
        end

        // Toggling noise alternates sign.
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 0, 0, i[0], 0, 1);
            lit("expl_toggle", int'($signed(sample_out)), i[0] ? 16256 : -16256);
        end

        // Walk into decay until the envelope is 100, then retrigger.
        n = 0;
        while (t_x < 3816 && n < 5000) begin
            cyc(1, 0, 0, 0, 1, 0, 1);
            n++;
        end
        lit("reach_env100", t_x, 3816);
        cyc(1, 0, 0, 0, 1, 0, 1);
        lit("expl_env100", int'($signed(sample_out)), 6400);
        cyc(0, 1, 0, 1, 1, 0, 1);
        lit("retrig_busy", int'(busy[0]), 1);
        cyc(1, 0, 0, 0, 1, 0, 1);
        lit("retrig_full", int'($signed(sample_out)), 16320);

        // Both channels loud.
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 1, 1, 1);
        n = 0;
        do begin
            n++;
            cyc(1, 0, 0, 0, 1, (n == 2) ? 1'b0 : 1'b1, 1);
            if (n == 1) lit("both_pos", int'($signed(sample_out)), 32640);
            if (n == 2) lit("both_cancel", int'($signed(sample_out)), 0);
        end while (busy[1] && n < 2000);
        lit("shell_len", n, 96 + 255 * 6);

        // Mute mid-decay; triggers ignored while muted.
        cyc(0, 0, 0, 0, 1, 1, 0);
        lit("mute_sample", int'($signed(sample_out)), 0);
        lit("mute_busy", int'(busy), 0);
        cyc(1, 1, 0, 1, 1, 1, 0);
        lit("mute_trig_busy", int'(busy), 0);
        lit("mute_tick_sample", int'($signed(sample_out)), 0);

        // Shell trigger coincident with a tick: that tick is not counted.
        cyc(1, 0, 1, 0, 0, 1, 1);
        n = 0;
        do begin
            n++;
            cyc(1, 0, 0, 0, 0, 1, 1);
        end while (busy[1] && n < 2000);
        lit("shell_coinc_len", n, 96 + 255 * 6);

        // Randomized traffic.
        for (int i = 0; i < 20000; i++) begin
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 299) == 0),
                ($urandom_range(0, 199) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 799) != 0));
        end

        // Async reset mid-burst.
        cyc(0, 1, 1, 1, 1, 1, 1);
        repeat (5) cyc(1, 0, 0, 0, 1, 1, 1);
        lit("pre_reset_busy", int'(busy), 3);
        #2;
        rst_n = 1'b0;
        #1;
        lit("async_sample", int'($signed(sample_out)), 0);
        lit("async_busy", int'(busy), 0);
        cyc(1, 0, 0, 0, 1, 1, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cyc(1, 0, 0, 0, 1, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
